matrix_addr_seq: RTL and testbench
==================================

Name: matrix_addr_seq

Overview:
- Parametrised address sequencer for the matrix-multiply accelerator, driving operand and result memories for C[M×N] = A[M×K] · B.
- Each beat emits one A/B address pair, plus the C write address on the last beat of each dot product.
- Adds over the first-generation FSM:
  - configurable address and dimension widths
  - independent base addresses
  - transposed-B mode
  - stall back-pressure, abort, and zero-size error reporting

Parameters:
AW, 8, address width of A, B and C memories; all address arithmetic is modulo 2^AW
DW, 8, dimension width; M, K, N range 1..2^DW-1

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  level start request; sampled only in IDLE
i_abort  input  1  terminate the current run
i_stall  input  1  hold the current beat (consumer not ready)
i_m  input  DW  rows of A / rows of C
i_k  input  DW  columns of A = dot-product length
i_n  input  DW  columns of C
i_base_a  input  AW  base address of A (row-major)
i_base_b  input  AW  base address of B
i_base_c  input  AW  base address of C (row-major)
i_b_trans  input  1  0: B stored K×N row-major; 1: B stored N×K row-major (B transposed)
o_a_adr  output  AW  A read address
o_b_adr  output  AW  B read address
o_c_adr  output  AW  C write address; meaningful when o_last=1
o_valid  output  1  beat present
o_first  output  1  first beat of a dot product (k=0); accumulator clear
o_last  output  1  last beat of a dot product (k=K-1); accumulator write
o_busy  output  1  high in RUN
o_done  output  1  one-cycle completion pulse
o_err  output  1  with o_done: zero dimension or abort

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs and counters 0.
- States: IDLE, RUN, HOLD.
- IDLE:
  - On i_start=1, latch all config inputs.
  - If any of M, K, N is 0: go to HOLD and pulse o_done with o_err=1 next cycle; no beats are issued.
  - Otherwise: go to RUN; the first beat (n=0, m=0, k=0) has o_valid=1 in the next cycle.
- RUN: loop order is n outer, m middle, k inner. Beat addresses:
  - a = base_a + m·K + k
  - b = base_b + k·N + n when b_trans=0; base_b + n·K + k when b_trans=1
  - c = base_c + m·N + n
- Addresses are generated incrementally; no multipliers:
  - a: +1 per beat; returns to base_a when m wraps.
  - b (b_trans=0): +N per k; at k wrap, returns to base_b+n; at m wrap, moves to base_b+n+1.
  - b (b_trans=1): +1 per k; at k wrap, returns to the registered row start; at m wrap, row start += K.
  - c: +N at each m step; at m wrap, moves to base_c+n+1.
- Flags: o_first=(k==0), o_last=(k==K-1); both qualified by o_valid.
- Stall: i_stall=1 in RUN freezes all counters, addresses and flags; o_valid stays 1. A beat is consumed only on a cycle with o_valid=1 and i_stall=0.
- Completion: the cycle after the final beat (n=N-1, m=M-1, k=K-1) is consumed, go to HOLD. In that cycle: o_valid=0, o_busy=0, o_done=1, o_err=0.
- Abort: i_abort=1 in RUN has priority over stall. Next cycle: HOLD, o_done=1, o_err=1, o_valid=0. Partial results are undefined.
- HOLD: stays in HOLD while i_start=1; returns to IDLE the cycle after i_start=0. A held start never retriggers a run.
- o_done is high for exactly one cycle per run. o_err is valid only with o_done and is 0 otherwise.
- Config input changes during RUN have no effect.
- Dimension 2^DW-1 with narrow AW: addresses wrap modulo 2^AW silently.

Decomposition:
- Package matrix_seq_pkg holds:
  - state encoding localparams (IDLE, RUN, HOLD)
  - default AW/DW constants
- Sub-module mat_wrap_cnt (DW-bit counter with enable, terminal-count flag and wrap-to-zero) is instantiated three times, for k, m and n. Terminal flags chain as carry enables.

Test Plan:
- Normal run: M=2, K=3, N=2, bases 0x00/0x40/0x80, b_trans=0, start at cycle 0 → 12 beats in cycles 1–12.
  - a: 0,1,2,3,4,5,0,1,2,3,4,5
  - b: 40,42,44,40,42,44,41,43,45,41,43,45
  - c on o_last: 80, 82, 81, 83
  - o_done=1, o_err=0 at cycle 13
- Same run with b_trans=1 → b: 40,41,42,40,41,42,43,44,45,43,44,45; a and c unchanged.
- Stall: same as the normal run, i_stall high for 3 cycles while the 5th beat is presented → beat 5 held with identical outputs for 4 cycles; 15 valid cycles total; o_done at cycle 16.
- Boundaries:
  - M=K=N=1 → single beat with o_first=o_last=1 at cycle 1; o_done at cycle 2.
  - K=0 → no o_valid; o_done=1 and o_err=1 at cycle 1.
- Control: i_start held high through completion → exactly one run and one o_done; a new run needs i_start low for ≥1 cycle, then high again.
- Interrupts:
  - i_abort at beat 4 → o_valid drops next cycle, with o_done=1 and o_err=1.
  - i_rst_n low mid-run → all outputs 0 immediately, without waiting for a clock edge; state IDLE.

Source files
------------

// File: rtl/matrix_addr_seq_pkg.sv
// Shared definitions for the matrix-multiply address sequencer.
// Holds the sequencer state encoding and the default address and
// dimension widths used by the interface, the counters and the top.
package matrix_seq_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    // IDLE waits for start, RUN issues beats, HOLD parks after a run
    // until start is released so a held start cannot retrigger.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_addr_seq_if.sv
// Control / configuration / beat bus of the matrix address sequencer.
// master: the controller that requests runs and consumes beats.
// slave : the sequencer itself.
//   i_start, i_abort, i_stall        run control and back-pressure
//   i_m, i_k, i_n                    matrix dimensions (DW bits)
//   i_base_a, i_base_b, i_base_c     memory base addresses (AW bits)
//   i_b_trans                        B stored transposed (N x K)
//   o_a_adr, o_b_adr, o_c_adr        beat addresses
//   o_valid, o_first, o_last         beat qualifiers
//   o_busy, o_done, o_err            run status
interface matrix_addr_seq_if #(
    parameter int AW = matrix_seq_pkg::DEF_AW,
    parameter int DW = matrix_seq_pkg::DEF_DW
) ();

    logic          i_start;
    logic          i_abort;
    logic          i_stall;
    logic [DW-1:0] i_m;
    logic [DW-1:0] i_k;
    logic [DW-1:0] i_n;
    logic [AW-1:0] i_base_a;
    logic [AW-1:0] i_base_b;
    logic [AW-1:0] i_base_c;
    logic          i_b_trans;
    logic [AW-1:0] o_a_adr;
    logic [AW-1:0] o_b_adr;
    logic [AW-1:0] o_c_adr;
    logic          o_valid;
    logic          o_first;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport master (
        output i_start, i_abort, i_stall, i_m, i_k, i_n,
               i_base_a, i_base_b, i_base_c, i_b_trans,
        input  o_a_adr, o_b_adr, o_c_adr, o_valid, o_first, o_last,
               o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_abort, i_stall, i_m, i_k, i_n,
               i_base_a, i_base_b, i_base_c, i_b_trans,
        output o_a_adr, o_b_adr, o_c_adr, o_valid, o_first, o_last,
               o_busy, o_done, o_err
    );

endinterface

// File: rtl/matrix_addr_seq_wrap_cnt.sv
// Loop index counter for the sequencer: counts 0..i_last and wraps to
// zero on the enabled step after the terminal value.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clr           synchronous clear to zero (wins over i_en)
//   i_en            advance one step
//   i_last          terminal value (loop length - 1)
//   o_cnt           current index
//   o_tc            index equals i_last; chains as the next loop's enable
module mat_wrap_cnt
    import matrix_seq_pkg::*;
#(
    parameter int W = DEF_DW
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    assign o_cnt = cnt_r;
    assign o_tc  = (cnt_r == i_last);

    // Next index: clear, wrap at terminal, increment, or hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (i_clr) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (i_en) begin
            if (o_tc) begin
                cnt_nxt_s = {W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + W'(1'b1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Index register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/matrix_addr_seq.sv
// Address sequencer for C[MxN] = A[MxK] * B. One A/B read address pair
// per beat, loop order n (outer), m, k (inner); the C write address is
// meaningful on the last beat of each dot product. Addresses are built
// incrementally (no multipliers) and wrap modulo 2^AW.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus (slave)     start/abort/stall, dimensions, bases, transpose mode,
//                   beat addresses and flags, busy/done/err status
module matrix_addr_seq
    import matrix_seq_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    matrix_addr_seq_if.slave bus
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic          load_s;
    logic          consume_s;
    logic          final_s;
    logic          zero_dim_s;
    logic          run_nxt_s;
    logic          done_nxt_s;
    logic          err_nxt_s;
    logic          first_nxt_s;
    logic          last_nxt_s;

    logic [DW-1:0] m_len_r;
    logic [DW-1:0] k_len_r;
    logic [DW-1:0] n_len_r;
    logic [AW-1:0] base_a_r;
    logic          b_trans_r;

    logic [AW-1:0] a_adr_r;
    logic [AW-1:0] b_adr_r;
    logic [AW-1:0] c_adr_r;
    logic [AW-1:0] b_row_r;   // b restart point at k wrap
    logic [AW-1:0] c_col_r;   // base_c + n
    logic [AW-1:0] b_k_step_s;
    logic [AW-1:0] b_row_step_s;

    logic [DW-1:0] k_cnt_s;
    logic [DW-1:0] m_cnt_unused_s;
    logic [DW-1:0] n_cnt_unused_s;
    logic          k_tc_s;
    logic          m_tc_s;
    logic          n_tc_s;

    logic          valid_r;
    logic          first_r;
    logic          last_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    assign zero_dim_s = (bus.i_m == {DW{1'b0}}) || (bus.i_k == {DW{1'b0}}) ||
                        (bus.i_n == {DW{1'b0}});
    assign final_s    = k_tc_s && m_tc_s && n_tc_s;
    assign run_nxt_s  = (state_nxt_s == ST_RUN);

    // Non-transposed B walks a column (stride N) and steps one column per
    // m wrap; transposed B walks a row (stride 1) and steps one row of K.
    assign b_k_step_s   = b_trans_r ? AW'(1'b1) : AW'(n_len_r);
    assign b_row_step_s = b_trans_r ? AW'(k_len_r) : AW'(1'b1);

    // Next state plus the load / consume / completion strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        consume_s   = 1'b0;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (zero_dim_s) begin
                        state_nxt_s = ST_HOLD;
                        done_nxt_s  = 1'b1;
                        err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        load_s      = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.i_abort) begin
                    state_nxt_s = ST_HOLD;
                    done_nxt_s  = 1'b1;
                    err_nxt_s   = 1'b1;
                end else if (!bus.i_stall) begin
                    consume_s = 1'b1;
                    if (final_s) begin
                        state_nxt_s = ST_HOLD;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (bus.i_start) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Configuration capture on a start seen in IDLE; frozen otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_len_r   <= {DW{1'b0}};
            k_len_r   <= {DW{1'b0}};
            n_len_r   <= {DW{1'b0}};
            base_a_r  <= {AW{1'b0}};
            b_trans_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.i_start) begin
            m_len_r   <= bus.i_m;
            k_len_r   <= bus.i_k;
            n_len_r   <= bus.i_n;
            base_a_r  <= bus.i_base_a;
            b_trans_r <= bus.i_b_trans;
        end else begin
            m_len_r   <= m_len_r;
            k_len_r   <= k_len_r;
            n_len_r   <= n_len_r;
            base_a_r  <= base_a_r;
            b_trans_r <= b_trans_r;
        end
    end

    mat_wrap_cnt #(.W(DW)) u_k_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (load_s),
        .i_en    (consume_s),
        .i_last  (k_len_r - DW'(1'b1)),
        .o_cnt   (k_cnt_s),
        .o_tc    (k_tc_s)
    );

    mat_wrap_cnt #(.W(DW)) u_m_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (load_s),
        .i_en    (consume_s && k_tc_s),
        .i_last  (m_len_r - DW'(1'b1)),
        .o_cnt   (m_cnt_unused_s),
        .o_tc    (m_tc_s)
    );

    mat_wrap_cnt #(.W(DW)) u_n_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (load_s),
        .i_en    (consume_s && k_tc_s && m_tc_s),
        .i_last  (n_len_r - DW'(1'b1)),
        .o_cnt   (n_cnt_unused_s),
        .o_tc    (n_tc_s)
    );

    // Beat flags for the next cycle, derived from the next k index.
    always_comb begin
        first_nxt_s = first_r;
        last_nxt_s  = last_r;
        if (!run_nxt_s) begin
            first_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
        end else if (load_s) begin
            first_nxt_s = 1'b1;
            last_nxt_s  = (bus.i_k == DW'(1'b1));
        end else if (consume_s) begin
            first_nxt_s = k_tc_s;
            if (k_tc_s) begin
                last_nxt_s = (k_len_r == DW'(1'b1));
            end else begin
                last_nxt_s = ((k_cnt_s + DW'(1'b1)) == (k_len_r - DW'(1'b1)));
            end
        end else begin
            first_nxt_s = first_r;
            last_nxt_s  = last_r;
        end
    end

    // Incremental address generation; cleared whenever not running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_adr_r <= {AW{1'b0}};
            b_adr_r <= {AW{1'b0}};
            c_adr_r <= {AW{1'b0}};
            b_row_r <= {AW{1'b0}};
            c_col_r <= {AW{1'b0}};
        end else if (load_s) begin
            a_adr_r <= bus.i_base_a;
            b_adr_r <= bus.i_base_b;
            c_adr_r <= bus.i_base_c;
            b_row_r <= bus.i_base_b;
            c_col_r <= bus.i_base_c;
        end else if (!run_nxt_s) begin
            a_adr_r <= {AW{1'b0}};
            b_adr_r <= {AW{1'b0}};
            c_adr_r <= {AW{1'b0}};
            b_row_r <= {AW{1'b0}};
            c_col_r <= {AW{1'b0}};
        end else if (consume_s) begin
            if (k_tc_s && m_tc_s) begin
                // m wraps: next output column n+1 starts from row 0
                a_adr_r <= base_a_r;
                b_adr_r <= b_row_r + b_row_step_s;
                b_row_r <= b_row_r + b_row_step_s;
                c_adr_r <= c_col_r + AW'(1'b1);
                c_col_r <= c_col_r + AW'(1'b1);
            end else if (k_tc_s) begin
                // next row of A, same B column, C moves down one row
                a_adr_r <= a_adr_r + AW'(1'b1);
                b_adr_r <= b_row_r;
                c_adr_r <= c_adr_r + AW'(n_len_r);
            end else begin
                a_adr_r <= a_adr_r + AW'(1'b1);
                b_adr_r <= b_adr_r + b_k_step_s;
            end
        end else begin
            a_adr_r <= a_adr_r;
            b_adr_r <= b_adr_r;
            c_adr_r <= c_adr_r;
            b_row_r <= b_row_r;
            c_col_r <= c_col_r;
        end
    end

    // Registered beat qualifiers and run status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= run_nxt_s;
            first_r <= first_nxt_s;
            last_r  <= last_nxt_s;
            busy_r  <= run_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.o_a_adr = a_adr_r;
    assign bus.o_b_adr = b_adr_r;
    assign bus.o_c_adr = c_adr_r;
    assign bus.o_valid = valid_r;
    assign bus.o_first = first_r;
    assign bus.o_last  = last_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_done  = done_r;
    assign bus.o_err   = err_r;

endmodule

// File: tb/tb_matrix_addr_seq.sv
// Bench for matrix_addr_seq: expected beats come from the matrix
// address formulas evaluated directly per (n, m, k) with masking.
module tb_matrix_addr_seq;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MASK = (1 << AW) - 1;

    typedef struct {
        int a;
        int b;
        int c;
        bit f;
        bit l;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    matrix_addr_seq_if #(.AW(AW), .DW(DW)) bus ();

    matrix_addr_seq #(.AW(AW), .DW(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_cfg();
        bus.i_m       = DW'($urandom);
        bus.i_k       = DW'($urandom);
        bus.i_n       = DW'($urandom);
        bus.i_base_a  = AW'($urandom);
        bus.i_base_b  = AW'($urandom);
        bus.i_base_c  = AW'($urandom);
        bus.i_b_trans = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.o_busy),  32'd0);
        chk({tag, "_done"},  32'(bus.o_done),  32'd0);
        chk({tag, "_err"},   32'(bus.o_err),   32'd0);
        chk({tag, "_first"}, 32'(bus.o_first), 32'd0);
        chk({tag, "_last"},  32'(bus.o_last),  32'd0);
        chk({tag, "_a"},     32'(bus.o_a_adr), 32'd0);
        chk({tag, "_b"},     32'(bus.o_b_adr), 32'd0);
        chk({tag, "_c"},     32'(bus.o_c_adr), 32'd0);
    endtask

    // One run: stall_pct random stall rate, stall_beat gets 3 forced stall
    // cycles, abort_at beat index to abort on (-1 none), hold_start keeps
    // i_start high through completion.
    task automatic run_case(input int m, input int k, input int n,
                            input int ba, input int bb, input int bc,
                            input bit tr, input int stall_pct, input int stall_beat,
                            input int abort_at, input bit hold_start);
        beat_t q[$];
        beat_t e;
        int    cyc;
        int    idx;
        int    stalls;
        int    held;
        bit    fin;
        bit    aborting;
        for (int nn = 0; nn < n; nn++)
            for (int mm = 0; mm < m; mm++)
                for (int kk = 0; kk < k; kk++) begin
                    e.a = (ba + mm * k + kk) & MASK;
                    e.b = tr ? ((bb + nn * k + kk) & MASK) : ((bb + kk * n + nn) & MASK);
                    e.c = (bc + mm * n + nn) & MASK;
                    e.f = (kk == 0);
                    e.l = (kk == k - 1);
                    q.push_back(e);
                end
        @(negedge clk);
        bus.i_m       = DW'(m);
        bus.i_k       = DW'(k);
        bus.i_n       = DW'(n);
        bus.i_base_a  = AW'(ba);
        bus.i_base_b  = AW'(bb);
        bus.i_base_c  = AW'(bc);
        bus.i_b_trans = tr;
        bus.i_start   = 1'b1;
        bus.i_abort   = 1'b0;
        bus.i_stall   = 1'b0;
        cyc = 0; idx = 0; stalls = 0; held = 0; fin = 1'b0; aborting = 1'b0;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) bus.i_start = 1'b0;
            scramble_cfg();
            bus.i_abort = 1'b0;
            if (aborting) begin
                chk("abort_valid", 32'(bus.o_valid), 32'd0);
                chk("abort_done",  32'(bus.o_done),  32'd1);
                chk("abort_err",   32'(bus.o_err),   32'd1);
                chk("abort_busy",  32'(bus.o_busy),  32'd0);
                fin = 1'b1;
            end else if (idx < q.size()) begin
                e = q[idx];
                chk("valid", 32'(bus.o_valid), 32'd1);
                chk("busy",  32'(bus.o_busy),  32'd1);
                chk("done",  32'(bus.o_done),  32'd0);
                chk("a_adr", 32'(bus.o_a_adr), 32'(e.a));
                chk("b_adr", 32'(bus.o_b_adr), 32'(e.b));
                chk("first", 32'(bus.o_first), 32'(e.f));
                chk("last",  32'(bus.o_last),  32'(e.l));
                if (e.l) chk("c_adr", 32'(bus.o_c_adr), 32'(e.c));
                if (idx == abort_at) begin
                    bus.i_abort = 1'b1;
                    bus.i_stall = 1'($urandom);
                    aborting = 1'b1;
                end else begin
                    bus.i_stall = ($urandom_range(99) < stall_pct);
                    if (idx == stall_beat && held < 3) begin
                        bus.i_stall = 1'b1;
                        held++;
                    end
                    if (bus.i_stall) stalls++;
                    else idx++;
                end
            end else begin
                chk("end_valid", 32'(bus.o_valid), 32'd0);
                chk("end_busy",  32'(bus.o_busy),  32'd0);
                chk("end_done",  32'(bus.o_done),  32'd1);
                chk("end_err",   32'(bus.o_err),   32'(q.size() == 0));
                chk("end_cycle", 32'(cyc),         32'(q.size() + stalls + 1));
                fin = 1'b1;
            end
        end
        chk("run_end", 32'(fin), 32'd1);
        bus.i_stall = 1'b0;
        bus.i_abort = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(bus.o_done), 32'd0);
        chk("err_clear",  32'(bus.o_err),  32'd0);
        if (hold_start) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("held_valid", 32'(bus.o_valid), 32'd0);
                chk("held_done",  32'(bus.o_done),  32'd0);
            end
        end
        bus.i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int m;
        int k;
        int n;
        int tot;
        int ab;
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_stall = 1'b0;
        scramble_cfg();
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_case(2, 3, 2, 8'h00, 8'h40, 8'h80, 1'b0, 0, -1, -1, 1'b0);
        run_case(2, 3, 2, 8'h00, 8'h40, 8'h80, 1'b1, 0, -1, -1, 1'b0);
        run_case(2, 3, 2, 8'h00, 8'h40, 8'h80, 1'b0, 0, 4, -1, 1'b0);
        run_case(1, 1, 1, 8'h11, 8'h22, 8'h33, 1'b0, 0, -1, -1, 1'b0);
        run_case(2, 0, 2, 8'h00, 8'h40, 8'h80, 1'b0, 0, -1, -1, 1'b0);
        run_case(2, 2, 2, 8'h10, 8'h20, 8'h30, 1'b1, 20, -1, -1, 1'b1);
        run_case(2, 3, 2, 8'h00, 8'h40, 8'h80, 1'b0, 0, -1, 3, 1'b0);
        run_case(1, 255, 2, 8'hF0, 8'hE0, 8'hFF, 1'b0, 10, -1, -1, 1'b0);
        run_case(2, 255, 1, 8'h80, 8'h7F, 8'h01, 1'b1, 0, -1, -1, 1'b0);

        // randomized cases
        for (int t = 0; t < 30; t++) begin
            m = $urandom_range(4, 1);
            k = $urandom_range(4, 1);
            n = $urandom_range(4, 1);
            if ($urandom_range(9) == 0) begin
                case ($urandom_range(2))
                    0: m = 0;
                    1: k = 0;
                    default: n = 0;
                endcase
            end
            tot = m * k * n;
            ab = (tot > 0 && $urandom_range(3) == 0) ? $urandom_range(tot - 1) : -1;
            run_case(m, k, n, $urandom_range(255), $urandom_range(255), $urandom_range(255),
                     1'($urandom), 30, -1, ab, 1'($urandom));
        end

        // asynchronous reset in the middle of a run
        @(negedge clk);
        bus.i_m = 8'd3; bus.i_k = 8'd3; bus.i_n = 8'd3;
        bus.i_base_a = 8'h05; bus.i_base_b = 8'h06; bus.i_base_c = 8'h07;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_rst");
        run_case(2, 3, 2, 8'h00, 8'h40, 8'h80, 1'b0, 0, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
